// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-burst scheduler in front of a single-port-style FIFO.
// Interleaves one-cycle read slots between bursts so reads never starve.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  localparam int IW       = $clog2(NREQ),
  localparam int BW       = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              rd_req,
  output logic              rd_ack,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_wr,
  output logic              fifo_rd,
  output logic [DW-1:0]     fifo_din,
  output logic [IW-1:0]     gnt_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    READ
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IW-1:0]  gnt_nx;
  logic [IW-1:0]  last_gnt;
  logic [IW-1:0]  last_nx;
  logic [BW-1:0]  burst_cnt;
  logic [BW-1:0]  cnt_nx;

  logic           any_req;
  logic           sel_vld;
  logic [DW-1:0]  sel_data;
  logic           last_beat;
  logic           burst_end;
  logic           rd_ok;

  logic [IW:0]    rot_sh;
  logic [NREQ-1:0] rot;
  logic [IW-1:0]  off;
  logic [IW:0]    pick_sum;
  logic [IW-1:0]  pick;

  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IW'(i)) begin
        sel_vld  = req_valid[i];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Rotate requests so bit 0 is the producer after last_gnt.
  always_comb begin
    rot_sh = {1'b0, last_gnt} + (IW+1)'(1);
    rot    = NREQ'({req_valid, req_valid} >> rot_sh);
    off    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    pick_sum = rot_sh + {1'b0, off};
    if (pick_sum >= (IW+1)'(NREQ)) begin
      pick_sum = pick_sum - (IW+1)'(NREQ);
    end
    pick = pick_sum[IW-1:0];
  end

  assign any_req  = |req_valid;
  assign rd_ok    = rd_req & ~fifo_empty;
  assign busy     = (state != IDLE);
  assign fifo_din = sel_data;

  assign fifo_wr = (state == GRANT) & sel_vld
                 & ~fifo_full;
  assign fifo_rd = (state == READ) & ~fifo_empty;
  assign rd_ack  = fifo_rd;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = fifo_wr & (gnt_id == IW'(i));
    end
  end

  assign last_beat = (burst_cnt == BW'(MAX_BURST - 1));

  // A full FIFO with a waiting reader ends the burst to avoid deadlock.
  assign burst_end = (fifo_wr & last_beat)
                   | ~sel_vld
                   | (fifo_full & rd_req);

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_id;
    last_nx  = last_gnt;
    cnt_nx   = burst_cnt;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = GRANT;
          gnt_nx   = pick;
          cnt_nx   = '0;
        end else if (rd_ok) begin
          state_nx = READ;
        end
      end
      GRANT: begin
        if (fifo_wr) begin
          cnt_nx = burst_cnt + BW'(1);
        end
        if (burst_end) begin
          last_nx  = gnt_id;
          state_nx = rd_ok ? READ : IDLE;
        end
      end
      READ: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_id    <= '0;
      last_gnt  <= IW'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      gnt_id    <= gnt_nx;
      last_gnt  <= last_nx;
      burst_cnt <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter with a transaction-level
// reference model and a queue standing in for the 16-deep FIFO.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rd_req;
  logic              rd_ack;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_wr;
  logic              fifo_rd;
  logic [DW-1:0]     fifo_din;
  logic [IW-1:0]     gnt_id;
  logic              busy;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DW(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rd_req(rd_req),
    .rd_ack(rd_ack), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_wr(fifo_wr),
    .fifo_rd(fifo_rd), .fifo_din(fifo_din),
    .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] pq [NREQ][$];
  logic [DW-1:0] fq [$];
  bit            on [NREQ];

  // model: ph 0=idle 1=granted 2=read slot
  int m_ph, m_own, m_cnt, m_prev;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph   = 0;
    m_own  = 0;
    m_cnt  = 0;
    m_prev = NREQ - 1;
  endtask

  task automatic add(input int p, input int n);
    repeat (n) pq[p].push_back(DW'($urandom));
  endtask

  task automatic cycle(input int rdp, input int rstp);
    logic [NREQ-1:0] v;
    logic [NREQ*DW-1:0] d;
    logic full, empty, rq, r, ewr, erd, done;
    logic [DW-1:0] edin;
    logic [NREQ-1:0] erdy;
    int n_ph, n_own, n_cnt, n_prev;
    @(negedge clk);
    r = ($urandom_range(99) < rstp);
    for (int i = 0; i < NREQ; i++) begin
      v[i] = !r && on[i] && (pq[i].size() > 0);
      d[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
    full  = (fq.size() >= DEPTH);
    empty = (fq.size() == 0);
    rq    = ($urandom_range(99) < rdp);
    rst        = r;
    req_valid  = v;
    req_data   = d;
    rd_req     = rq;
    fifo_full  = full;
    fifo_empty = empty;
    #1;
    ewr  = (m_ph == 1) && v[m_own] && !full;
    erd  = (m_ph == 2) && !empty;
    edin = d[m_own*DW +: DW];
    erdy = '0;
    if (ewr) erdy[m_own] = 1'b1;
    chk("fifo_wr", fifo_wr, ewr);
    chk("req_ready", req_ready, erdy);
    chk("fifo_rd", fifo_rd, erd);
    chk("rd_ack", rd_ack, erd);
    chk("gnt_id", gnt_id, m_own);
    chk("busy", busy, m_ph != 0);
    chk("fifo_din", fifo_din, edin);
    chk("wr_rd_excl", fifo_wr & fifo_rd, 1'b0);
    n_ph = m_ph; n_own = m_own;
    n_cnt = m_cnt; n_prev = m_prev;
    done = 1'b0;
    case (m_ph)
      0: begin
        if (|v) begin
          n_ph = 1;
          n_cnt = 0;
          for (int k = NREQ; k >= 1; k--)
            if (v[(m_prev + k) % NREQ])
              n_own = (m_prev + k) % NREQ;
        end else if (rq && !empty) begin
          n_ph = 2;
        end
      end
      1: begin
        if (ewr) n_cnt = m_cnt + 1;
        done = (ewr && n_cnt == MB) || !v[m_own]
             || (full && rq);
        if (done) begin
          n_prev = m_own;
          n_ph = (rq && !empty) ? 2 : 0;
        end
      end
      default: n_ph = 0;
    endcase
    @(posedge clk);
    if (r) begin
      fq.delete();
      m_reset();
    end else begin
      if (ewr) begin
        fq.push_back(edin);
        void'(pq[m_own].pop_front());
      end else if (erd) begin
        void'(fq.pop_front());
      end
      m_ph = n_ph; m_own = n_own;
      m_cnt = n_cnt; m_prev = n_prev;
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = 32'hA1B2C3D4;
    rd_req     = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b1;
    for (int i = 0; i < NREQ; i++) on[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 4'b0);
    chk("rst_wr", fifo_wr, 1'b0);
    chk("rst_rd", fifo_rd, 1'b0);
    chk("rst_ack", rd_ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt_id, 2'd0);
    chk("rst_din", fifo_din, 8'hD4);
    m_reset();

    // producer 0 alone, 10 words, no reads
    on[0] = 1'b1;
    add(0, 10);
    repeat (40) cycle(0, 0);
    chk("p0_words", fq.size(), 10);

    // all producers, no reads: fills and stalls
    for (int i = 0; i < NREQ; i++) begin
      on[i] = 1'b1;
      add(i, 8);
    end
    repeat (60) cycle(0, 0);
    chk("fill_full", fq.size(), DEPTH);

    // mixed traffic with reads
    repeat (300) begin
      if ($urandom_range(99) < 30)
        add($urandom_range(NREQ - 1), 1);
      cycle(40, 0);
    end

    // random producers, reads and resets
    repeat (3000) begin
      if ($urandom_range(99) < 2)
        on[$urandom_range(NREQ - 1)] ^= 1'b1;
      if ($urandom_range(99) < 45)
        add($urandom_range(NREQ - 1), 1);
      cycle(50, 1);
    end

    // drain with no producers
    for (int i = 0; i < NREQ; i++) on[i] = 1'b0;
    repeat (60) cycle(100, 0);
    chk("drained", fq.size(), 0);

    // reset after two writes of a burst from producer 3
    on[3] = 1'b1;
    add(3, 8);
    repeat (3) cycle(0, 0);
    chk("pre_rst_wr", fq.size(), 2);
    on[0] = 1'b1;
    add(0, 4);
    cycle(0, 100);
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_wr", fifo_wr, 1'b0);
    cycle(0, 0);
    #1;
    chk("post_rst_gnt", gnt_id, 2'd0);
    repeat (20) cycle(30, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
